pipe_result_accum: RTL and testbench
====================================

// Module: pipe_result_accum
// PURPOSE
//  Downstream consumer of the two-stage C*(A±B) arithmetic pipeline.
//  - Takes each 16-bit second-stage result as a signed two's-complement sample.
//  - Accumulates FRAME_LEN samples into a frame sum and presents it on a valid/ready output.
//  - A flush closes a partial frame early.
//  - The accumulator holds input back-pressure while the frame sum is waiting to be taken.
// PARAMETERS
//  DATA_W     16  input sample width (signed two's complement)
//  ACC_W      24  accumulator / out_sum width, signed; must be >= DATA_W
//  FRAME_LEN  8   samples per full frame, 2..255
// PORTS
//  clk          in   1       single clock, rising edge
//  reset        in   1       asynchronous, active-high reset
//  in_valid     in   1       in_data holds a sample
//  in_ready     out  1       accumulator can take a sample
//  in_data      in   DATA_W  sample from the pipeline result
//  flush        in   1       close the current frame now
//  out_valid    out  1       out_sum/out_count/flags valid
//  out_ready    in   1       consumer takes the frame result
//  out_sum      out  ACC_W   signed frame sum
//  out_count    out  8       samples in the frame, 1..FRAME_LEN
//  out_partial  out  1       frame was closed by flush (out_count < FRAME_LEN)
//  out_sat      out  1       saturation occurred in this frame (0 unless ACC_SAT_EN)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=ACCUM, acc=0, cnt=0, and all outputs 0.
//    in_ready follows state and reads 1 once ACCUM is entered.
//  - Beat: in_valid & in_ready. The sample is sign-extended to ACC_W and added to acc. cnt increments.
//  - FSM ACCUM (in_ready=1, out_valid=0):
//    - Beat with cnt==FRAME_LEN-1: register the results and go to HOLD with out_partial=0.
//      out_sum=acc+sample, out_count=FRAME_LEN.
//    - flush with cnt>0 and no beat: register out_sum=acc, out_count=cnt, out_partial=1, go to HOLD.
//    - flush in the same cycle as a beat: the beat is included first, then the frame closes.
//      out_partial=1 unless this beat completes a full frame.
//    - flush with cnt==0 and no beat: ignored.
//  - FSM HOLD (in_ready=0, out_valid=1):
//    - All out_* fields stay stable until out_ready.
//    - On out_ready: acc=0, cnt=0, out_valid=0 in the next cycle, go to ACCUM.
//    - flush is ignored in HOLD.
//  - Latency and throughput:
//    - out_valid rises in the cycle after the closing beat or flush.
//    - Minimum one-cycle bubble per frame (in_ready=0 while in HOLD).
//  - Reset mid-frame or mid-HOLD discards the partial sum and any pending result. No output is produced.
//  - Arithmetic is signed at ACC_W. Overflow handling is set by CONFIGURATION.
// CONFIGURATION
//  ACC_SAT_EN defined:
//    - Each add saturates to +(2^(ACC_W-1)-1) or -(2^(ACC_W-1)).
//    - out_sat=1 if any add in the frame clipped. It clears when the frame is accepted.
//  ACC_SAT_EN undefined:
//    - Adds wrap modulo 2^ACC_W.
//    - out_sat is tied to 0 and no saturation logic is generated.
// STRUCTURE
//  - Shared header pipe_accum_defs.vh: state encodings (ST_ACCUM=1'b0, ST_HOLD=1'b1),
//    default widths, and the out_count width constant (8).
//  - Sub-module pipe_sat_add: combinational signed ACC_W adder.
//    Returns the sum and a clip flag. Its saturation path is compiled under ACC_SAT_EN.
//  - Top module: FSM, acc/cnt registers, and output holding registers.
// TESTING
//  1. Defaults, out_ready=1: 8 beats of data 1..8.
//     -> out_sum=36, out_count=8, out_partial=0, out_valid for exactly 1 cycle.
//  2. 8 beats of 16'hFFFF (-1).
//     -> out_sum=24'hFFFFF8 (-8), out_count=8.
//  3. Back-pressure: full frame, then out_ready=0 for 5 cycles.
//     -> in_ready=0 and out_sum constant for all 5. Accepted on cycle 6, after which in_ready=1.
//  4. Flush: 3 beats of 100, then flush alone.
//     -> out_sum=300, out_count=3, out_partial=1. A flush with cnt==0 produces no out_valid.
//  5. Reset: assert reset after 5 beats, release, then 8 beats of 2.
//     -> out_sum=16, out_count=8. No result from the aborted frame.
//  6. ACC_W=18: 8 beats of 16'h7FFF.
//     -> with ACC_SAT_EN: out_sum=18'h1FFFF, out_sat=1.
//     -> without: out_sum=18'h3FFF8, out_sat=0.

Source files
------------

// File: rtl/pipe_result_accum_pkg.sv
// Shared definitions for the frame accumulator: FSM state encodings, default widths
// and the out_count width. Imported by pipe_result_accum.
package pipe_result_accum_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_ACC_W     = 24;
    localparam int DEF_FRAME_LEN = 8;
    localparam int CNT_W         = 8;

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_result_accum_sat_add.sv
// Combinational signed ACC_W adder. With ACC_SAT_EN defined the sum clips to the signed
// range and a clip flag is produced; otherwise the sum wraps and no clip port exists.
module pipe_result_accum_sat_add #(
    parameter int ACC_W = 24
) (
`ifdef ACC_SAT_EN
    output logic                    clip,
`endif
    input  logic signed [ACC_W-1:0] a,
    input  logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0] sum
);

`ifdef ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] wide;

    always_comb begin
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        clip = 1'b0;
        sum  = wide[ACC_W-1:0];
        // The two top bits disagree only when the true sum left the ACC_W range.
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            clip = 1'b1;
            sum  = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    assign sum = a + b;
`endif

endmodule

// File: rtl/pipe_result_accum.sv
// Frame accumulator for the C*(A+-B) pipeline results: sums FRAME_LEN signed samples (or a
// flushed partial frame) and holds the result on a valid/ready port. Optional macro: ACC_SAT_EN.
module pipe_result_accum
    import pipe_result_accum_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ACC_W     = DEF_ACC_W,
    parameter int FRAME_LEN = DEF_FRAME_LEN
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_sum,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_partial,
    output logic              out_sat
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic        [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [ACC_W-1:0]   out_sum_q, out_sum_d;
    logic        [CNT_W-1:0]   out_count_q, out_count_d;
    logic                      out_partial_q, out_partial_d;

    logic signed [DATA_W-1:0]  in_data_s;
    logic signed [ACC_W-1:0]   sample_ext;
    logic signed [ACC_W-1:0]   add_sum;
    logic                      beat;

`ifdef ACC_SAT_EN
    logic                      add_clip;
    logic                      frame_sat_q, frame_sat_d;
    logic                      out_sat_q, out_sat_d;
`endif

    assign in_data_s  = in_data;
    assign sample_ext = ACC_W'(in_data_s);
    assign beat       = in_valid && (state_q == ST_ACCUM);

    pipe_result_accum_sat_add #(
        .ACC_W (ACC_W)
    ) u_add (
`ifdef ACC_SAT_EN
        .clip  (add_clip),
`endif
        .a     (acc_q),
        .b     (sample_ext),
        .sum   (add_sum)
    );

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        cnt_d         = cnt_q;
        out_sum_d     = out_sum_q;
        out_count_d   = out_count_q;
        out_partial_d = out_partial_q;
`ifdef ACC_SAT_EN
        frame_sat_d   = frame_sat_q;
        out_sat_d     = out_sat_q;
`endif
        unique case (state_q)
            ST_ACCUM: begin
                if (beat) begin
                    acc_d = add_sum;
                    cnt_d = cnt_q + CNT_ONE;
`ifdef ACC_SAT_EN
                    frame_sat_d = frame_sat_q | add_clip;
`endif
                    // A flush alongside a beat closes the frame with that beat included.
                    if ((cnt_q == LAST_IDX) || flush) begin
                        out_sum_d     = add_sum;
                        out_count_d   = cnt_q + CNT_ONE;
                        out_partial_d = (cnt_q != LAST_IDX);
`ifdef ACC_SAT_EN
                        out_sat_d     = frame_sat_q | add_clip;
`endif
                        state_d       = ST_HOLD;
                    end
                end else if (flush && (cnt_q != '0)) begin
                    out_sum_d     = acc_q;
                    out_count_d   = cnt_q;
                    out_partial_d = 1'b1;
`ifdef ACC_SAT_EN
                    out_sat_d     = frame_sat_q;
`endif
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
`ifdef ACC_SAT_EN
                    frame_sat_d = 1'b0;
`endif
                    state_d = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_ACCUM;
            acc_q         <= '0;
            cnt_q         <= '0;
            out_sum_q     <= '0;
            out_count_q   <= '0;
            out_partial_q <= 1'b0;
`ifdef ACC_SAT_EN
            frame_sat_q   <= 1'b0;
            out_sat_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            out_sum_q     <= out_sum_d;
            out_count_q   <= out_count_d;
            out_partial_q <= out_partial_d;
`ifdef ACC_SAT_EN
            frame_sat_q   <= frame_sat_d;
            out_sat_q     <= out_sat_d;
`endif
        end
    end

    assign in_ready    = (state_q == ST_ACCUM);
    assign out_valid   = (state_q == ST_HOLD);
    assign out_sum     = out_sum_q;
    assign out_count   = out_count_q;
    assign out_partial = out_partial_q;
`ifdef ACC_SAT_EN
    assign out_sat     = out_sat_q;
`else
    assign out_sat     = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_result_accum.sv
// Scoreboard bench for pipe_result_accum: directed frames, back-pressure, flush, reset,
// a narrow-accumulator overflow case, and a randomized handshake phase.
module tb_pipe_result_accum;

    localparam int ACC_W     = 24;
    localparam int FRAME_LEN = 8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [15:0] in_data = '0;
    logic        in_ready, out_valid, out_partial, out_sat;
    logic [23:0] out_sum;
    logic [7:0]  out_count;

    logic        in_valid2 = 1'b0, flush2 = 1'b0, out_ready2 = 1'b1;
    logic [15:0] in_data2 = '0;
    logic        in_ready2, out_valid2, out_partial2, out_sat2;
    logic [17:0] out_sum2;
    logic [7:0]  out_count2;

    pipe_result_accum u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_count(out_count), .out_partial(out_partial), .out_sat(out_sat)
    );

    pipe_result_accum #(.DATA_W(16), .ACC_W(18), .FRAME_LEN(8)) u_dut18 (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .flush(flush2), .out_valid(out_valid2), .out_ready(out_ready2),
        .out_sum(out_sum2), .out_count(out_count2), .out_partial(out_partial2), .out_sat(out_sat2)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of accepted samples.
    typedef struct {
        logic [23:0] sum;
        logic [7:0]  count;
        logic        partial;
        logic        sat;
    } frame_t;

    frame_t exp_q[$];
    longint samples[$];
    bit     model_hold = 1'b0;

    function automatic frame_t close_frame(input bit partial);
        frame_t f;
        longint s    = 0;
        bit     sat  = 1'b0;
        longint maxv = (longint'(1) << (ACC_W - 1)) - 1;
        longint minv = -(longint'(1) << (ACC_W - 1));
        foreach (samples[i]) begin
            s += samples[i];
`ifdef ACC_SAT_EN
            if (s > maxv) begin s = maxv; sat = 1'b1; end
            else if (s < minv) begin s = minv; sat = 1'b1; end
`endif
        end
        f.sum     = s[23:0];
        f.count   = 8'(samples.size());
        f.partial = partial;
        f.sat     = sat;
        return f;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            samples.delete();
            exp_q.delete();
            model_hold = 1'b0;
        end else if (model_hold) begin
            if (out_ready) model_hold = 1'b0;
        end else if (in_valid) begin
            samples.push_back(longint'($signed(in_data)));
            if (samples.size() == FRAME_LEN || flush) begin
                exp_q.push_back(close_frame(samples.size() != FRAME_LEN));
                samples.delete();
                model_hold = 1'b1;
            end
        end else if (flush && samples.size() > 0) begin
            exp_q.push_back(close_frame(1'b1));
            samples.delete();
            model_hold = 1'b1;
        end
    end

    int          frames_done = 0;
    logic [23:0] last_sum;
    logic [7:0]  last_count;
    logic        last_partial;

    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", in_ready, !model_hold);
            chk("out_valid", out_valid, model_hold);
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: got sum=%0h count=%0d expected no frame", out_sum, out_count);
                end else begin
                    chk("out_sum", out_sum, exp_q[0].sum);
                    chk("out_count", out_count, exp_q[0].count);
                    chk("out_partial", out_partial, exp_q[0].partial);
                    chk("out_sat", out_sat, exp_q[0].sat);
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        frames_done++;
                        last_sum     = out_sum;
                        last_count   = out_count;
                        last_partial = out_partial;
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] d, input bit fl);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        flush    = fl;
        while (!in_ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 100) begin
            checks++;
            failures++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic flush_only();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_frame(input int target);
        int g = 0;
        while (frames_done < target && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        chk("frame_arrived", 64'(frames_done >= target), 64'd1);
    endtask

    task automatic chk_last(input string name, input logic [23:0] s, input logic [7:0] c, input logic p);
        chk({name, "_sum"}, last_sum, s);
        chk({name, "_count"}, last_count, c);
        chk({name, "_partial"}, last_partial, p);
    endtask

    initial begin
        int n;
        logic [17:0] exp18_sum;
        logic        exp18_sat;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_sum", out_sum, 24'h0);
        chk("rst_out_count", out_count, 8'h0);
        chk("rst_out_partial", out_partial, 1'b0);
        chk("rst_out_sat", out_sat, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1'b1);

        // Narrow accumulator: eight maximum positive samples overflow 18 bits.
        in_valid2 = 1'b1;
        in_data2  = 16'h7FFF;
        repeat (8) begin @(posedge clk); #1; end
        in_valid2 = 1'b0;
`ifdef ACC_SAT_EN
        exp18_sum = 18'h1FFFF;
        exp18_sat = 1'b1;
`else
        exp18_sum = 18'h3FFF8;
        exp18_sat = 1'b0;
`endif
        chk("w18_out_valid", out_valid2, 1'b1);
        chk("w18_out_sum", out_sum2, exp18_sum);
        chk("w18_out_sat", out_sat2, exp18_sat);
        chk("w18_out_count", out_count2, 8'd8);
        chk("w18_out_partial", out_partial2, 1'b0);
        idle(2);
        chk("w18_released", out_valid2, 1'b0);

        n = frames_done;
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
        wait_frame(n + 1);
        chk_last("ramp", 24'd36, 8'd8, 1'b0);

        n = frames_done;
        repeat (8) send(16'hFFFF, 1'b0);
        wait_frame(n + 1);
        chk_last("neg", 24'hFFFFF8, 8'd8, 1'b0);

        n = frames_done;
        out_ready = 1'b0;
        for (int i = 10; i <= 17; i++) send(16'(i), 1'b0);
        for (int k = 0; k < 5; k++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_out_sum", out_sum, 24'd108);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_in_ready_after", in_ready, 1'b1);
        wait_frame(n + 1);
        chk_last("bp", 24'd108, 8'd8, 1'b0);

        n = frames_done;
        repeat (3) send(16'd100, 1'b0);
        flush_only();
        wait_frame(n + 1);
        chk_last("flush", 24'd300, 8'd3, 1'b1);
        flush_only();
        idle(3);
        chk("flush_empty", 64'(frames_done), 64'(n + 1));

        n = frames_done;
        send(16'd7, 1'b0);
        send(16'd8, 1'b0);
        send(16'd9, 1'b0);
        send(16'hFFFB, 1'b1);
        wait_frame(n + 1);
        chk_last("flush_beat", 24'd19, 8'd4, 1'b1);
        repeat (7) send(16'd3, 1'b0);
        send(16'd4, 1'b1);
        wait_frame(n + 2);
        chk_last("flush_last", 24'd25, 8'd8, 1'b0);

        n = frames_done;
        repeat (5) send(16'd50, 1'b0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (8) send(16'd2, 1'b0);
        wait_frame(n + 1);
        chk_last("reset", 24'd16, 8'd8, 1'b0);
        idle(3);
        chk("reset_one_frame", 64'(frames_done), 64'(n + 1));

        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = 16'($urandom);
            flush     = ($urandom_range(0, 9) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = (c == 250);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
